// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory between the processor and a debug/loader port.
// Each access is held for WAIT_CYC+1 memory cycles, followed by a one-cycle ack to the winner.
module mem_port_arbiter #(
    parameter int WIDTH    = 8,
    parameter int AWIDTH   = 8,
    parameter int WAIT_CYC = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [AWIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0]  cpu_wd,
    output logic [WIDTH-1:0]  cpu_rd,
    output logic              cpu_ack,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [AWIDTH-1:0] dbg_adr,
    input  logic [WIDTH-1:0]  dbg_wd,
    output logic [WIDTH-1:0]  dbg_rd,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0]  mem_wd,
    input  logic [WIDTH-1:0]  mem_rd,
    output logic              busy,
    output logic              gnt_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACC    = 2'b01,
        DONE   = 2'b10,
        UNUSED = 2'b11
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       last_dbg;
    logic       we_lat;
    logic       any_req;
    logic       pick_dbg;

    // On a tie the port that did not win last time is chosen.
    always_comb begin
        any_req  = cpu_req | dbg_req;
        pick_dbg = dbg_req & (~cpu_req | ~last_dbg);
    end

    assign gnt_dbg = last_dbg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        cpu_ack   = 1'b0;
        dbg_ack   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ACC;
                end
            end
            ACC: begin
                mem_en = 1'b1;
                mem_we = we_lat;
                busy   = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                cpu_ack   = ~last_dbg;
                dbg_ack   = last_dbg;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Requester inputs are sampled only on the grant edge; later changes cannot disturb the access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= 4'd0;
            last_dbg <= 1'b1;
            we_lat   <= 1'b0;
            mem_adr  <= '0;
            mem_wd   <= '0;
            cpu_rd   <= '0;
            dbg_rd   <= '0;
        end else if (state == IDLE) begin
            if (any_req) begin
                we_lat   <= pick_dbg ? dbg_we : cpu_we;
                mem_adr  <= pick_dbg ? dbg_adr : cpu_adr;
                mem_wd   <= pick_dbg ? dbg_wd : cpu_wd;
                cnt      <= WAIT_INIT;
                last_dbg <= pick_dbg;
            end
        end else if (state == ACC) begin
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else if (!we_lat) begin
                if (last_dbg) begin
                    dbg_rd <= mem_rd;
                end else begin
                    cpu_rd <= mem_rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a default build plus WAIT_CYC=0 and WAIT_CYC=3 builds
// driven from a small read-only memory model.
module tb_mem_port_arbiter;

    logic       clk;
    logic       reset;
    logic       cpu_req, cpu_we, dbg_req, dbg_we;
    logic [7:0] cpu_adr, cpu_wd, dbg_adr, dbg_wd;
    logic [7:0] cpu_rd, dbg_rd, mem_adr, mem_wd, mem_rd;
    logic       cpu_ack, dbg_ack, mem_en, mem_we, busy, gnt_dbg;

    logic       cpu_req0, cpu_req3, no_req;
    logic [7:0] cpu_rd0, dbg_rd0, mem_adr0, mem_wd0, mem_rd0;
    logic [7:0] cpu_rd3, dbg_rd3, mem_adr3, mem_wd3, mem_rd3;
    logic       cpu_ack0, dbg_ack0, mem_en0, mem_we0, busy0, gnt_dbg0;
    logic       cpu_ack3, dbg_ack3, mem_en3, mem_we3, busy3, gnt_dbg3;

    int vectors;
    int miscompares;

    function automatic logic [7:0] rom(input logic [7:0] a);
        case (a)
            8'h10:   rom = 8'h8C;
            8'h20:   rom = 8'h3C;
            8'h30:   rom = 8'h5A;
            8'h44:   rom = 8'hC3;
            8'h50:   rom = 8'h77;
            default: rom = a ^ 8'hFF;
        endcase
    endfunction

    assign mem_rd  = rom(mem_adr);
    assign mem_rd0 = rom(mem_adr0);
    assign mem_rd3 = rom(mem_adr3);

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wd(dbg_wd),
        .dbg_rd(dbg_rd), .dbg_ack(dbg_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wd(mem_wd),
        .mem_rd(mem_rd), .busy(busy), .gnt_dbg(gnt_dbg)
    );

    mem_port_arbiter #(.WAIT_CYC(0)) dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req0), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd0), .cpu_ack(cpu_ack0),
        .dbg_req(no_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wd(dbg_wd),
        .dbg_rd(dbg_rd0), .dbg_ack(dbg_ack0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_adr(mem_adr0), .mem_wd(mem_wd0),
        .mem_rd(mem_rd0), .busy(busy0), .gnt_dbg(gnt_dbg0)
    );

    mem_port_arbiter #(.WAIT_CYC(3)) dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req3), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
        .cpu_rd(cpu_rd3), .cpu_ack(cpu_ack3),
        .dbg_req(no_req), .dbg_we(dbg_we), .dbg_adr(dbg_adr), .dbg_wd(dbg_wd),
        .dbg_rd(dbg_rd3), .dbg_ack(dbg_ack3),
        .mem_en(mem_en3), .mem_we(mem_we3), .mem_adr(mem_adr3), .mem_wd(mem_wd3),
        .mem_rd(mem_rd3), .busy(busy3), .gnt_dbg(gnt_dbg3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset   = 1'b0;
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        cpu_adr = 8'h20;
        #3;
        vectors++; if (mem_en !== 1'b0) begin $display("FAIL rst_mem_en: got %b want 0", mem_en); miscompares++; end
        vectors++; if (cpu_ack !== 1'b0 || dbg_ack !== 1'b0) begin $display("FAIL rst_acks: got %b%b want 00", cpu_ack, dbg_ack); miscompares++; end
        vectors++; if (cpu_rd !== 8'h00) begin $display("FAIL rst_cpu_rd: got %h want 00", cpu_rd); miscompares++; end
        vectors++; if (busy !== 1'b0 || mem_adr !== 8'h00) begin $display("FAIL rst_busy_adr: got %b %h want 0 00", busy, mem_adr); miscompares++; end
        tick;
        vectors++; if (mem_en !== 1'b0 || busy !== 1'b0) begin $display("FAIL rst_held_edge: got en=%b busy=%b want 0 0", mem_en, busy); miscompares++; end
        reset = 1'b1;
        tick;
        vectors++; if (busy !== 1'b1 || mem_en !== 1'b1) begin $display("FAIL rst_grant: got busy=%b en=%b want 1 1", busy, mem_en); miscompares++; end
        vectors++; if (mem_adr !== 8'h20) begin $display("FAIL rst_grant_adr: got %h want 20", mem_adr); miscompares++; end
        tick;
        vectors++; if (mem_en !== 1'b1 || cpu_ack !== 1'b0) begin $display("FAIL rst_cycle2: got en=%b ack=%b want 1 0", mem_en, cpu_ack); miscompares++; end
        tick;
        vectors++; if (cpu_ack !== 1'b1 || dbg_ack !== 1'b0) begin $display("FAIL rst_cycle3_ack: got cpu=%b dbg=%b want 1 0", cpu_ack, dbg_ack); miscompares++; end
        vectors++; if (cpu_rd !== 8'h3C || mem_en !== 1'b0) begin $display("FAIL rst_cycle3_rd: got rd=%h en=%b want 3c 0", cpu_rd, mem_en); miscompares++; end
        cpu_req = 1'b0;
        tick;
        vectors++; if (busy !== 1'b0 || cpu_ack !== 1'b0) begin $display("FAIL rst_back_idle: got busy=%b ack=%b want 0 0", busy, cpu_ack); miscompares++; end
    endtask

    task automatic test_cpu_read;
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        cpu_adr = 8'h10;
        tick;
        vectors++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_adr !== 8'h10) begin $display("FAIL rd_acc1: got en=%b we=%b adr=%h want 1 0 10", mem_en, mem_we, mem_adr); miscompares++; end
        tick;
        vectors++; if (mem_en !== 1'b1 || cpu_ack !== 1'b0) begin $display("FAIL rd_acc2: got en=%b ack=%b want 1 0", mem_en, cpu_ack); miscompares++; end
        tick;
        vectors++; if (cpu_ack !== 1'b1 || mem_en !== 1'b0) begin $display("FAIL rd_ack: got ack=%b en=%b want 1 0", cpu_ack, mem_en); miscompares++; end
        vectors++; if (cpu_rd !== 8'h8C) begin $display("FAIL rd_cpu_rd: got %h want 8c", cpu_rd); miscompares++; end
        vectors++; if (dbg_rd !== 8'h00) begin $display("FAIL rd_dbg_rd: got %h want 00", dbg_rd); miscompares++; end
        cpu_req = 1'b0;
        tick;
        vectors++; if (cpu_ack !== 1'b0 || busy !== 1'b0) begin $display("FAIL rd_single_ack: got ack=%b busy=%b want 0 0", cpu_ack, busy); miscompares++; end
    endtask

    task automatic test_dbg_write;
        dbg_req = 1'b1;
        dbg_we  = 1'b1;
        dbg_adr = 8'h44;
        dbg_wd  = 8'hA5;
        tick;
        vectors++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin $display("FAIL wr_strobes: got en=%b we=%b want 1 1", mem_en, mem_we); miscompares++; end
        vectors++; if (mem_adr !== 8'h44 || mem_wd !== 8'hA5) begin $display("FAIL wr_bus: got adr=%h wd=%h want 44 a5", mem_adr, mem_wd); miscompares++; end
        vectors++; if (gnt_dbg !== 1'b1) begin $display("FAIL wr_gnt_dbg: got %b want 1", gnt_dbg); miscompares++; end
        tick;
        tick;
        vectors++; if (dbg_ack !== 1'b1 || cpu_ack !== 1'b0) begin $display("FAIL wr_ack: got dbg=%b cpu=%b want 1 0", dbg_ack, cpu_ack); miscompares++; end
        vectors++; if (cpu_rd !== 8'h8C || dbg_rd !== 8'h00) begin $display("FAIL wr_rd_regs: got cpu=%h dbg=%h want 8c 00", cpu_rd, dbg_rd); miscompares++; end
        dbg_req = 1'b0;
        tick;
        vectors++; if (dbg_ack !== 1'b0 || busy !== 1'b0) begin $display("FAIL wr_single_ack: got ack=%b busy=%b want 0 0", dbg_ack, busy); miscompares++; end
    endtask

    task automatic test_back_to_back;
        int   acks;
        logic want_dbg;
        acks     = 0;
        want_dbg = 1'b0;
        cpu_we   = 1'b0;
        cpu_adr  = 8'h10;
        dbg_we   = 1'b0;
        dbg_adr  = 8'h44;
        cpu_req  = 1'b1;
        dbg_req  = 1'b1;
        for (int n = 0; n < 40 && acks < 6; n++) begin
            tick;
            vectors++; if (cpu_ack && dbg_ack) begin $display("FAIL rr_overlap: got both acks high want one"); miscompares++; end
            if (cpu_ack || dbg_ack) begin
                vectors++; if (dbg_ack !== want_dbg || cpu_ack !== ~want_dbg) begin $display("FAIL rr_order%0d: got dbg_ack=%b want %b", acks, dbg_ack, want_dbg); miscompares++; end
                vectors++; if (gnt_dbg !== want_dbg) begin $display("FAIL rr_gnt%0d: got %b want %b", acks, gnt_dbg, want_dbg); miscompares++; end
                want_dbg = ~want_dbg;
                acks++;
            end
        end
        vectors++; if (acks != 6) begin $display("FAIL rr_count: got %0d acks want 6", acks); miscompares++; end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        tick;
        vectors++; if (busy !== 1'b0) begin $display("FAIL rr_idle: got busy=%b want 0", busy); miscompares++; end
        vectors++; if (cpu_rd !== 8'h8C || dbg_rd !== 8'hC3) begin $display("FAIL rr_rd_regs: got cpu=%h dbg=%h want 8c c3", cpu_rd, dbg_rd); miscompares++; end
    endtask

    task automatic test_wait_states;
        int ack0_cyc, ack3_cyc, en0_cnt, en3_cnt;
        ack0_cyc = 0;
        ack3_cyc = 0;
        en0_cnt  = 0;
        en3_cnt  = 0;
        cpu_we   = 1'b0;
        cpu_adr  = 8'h30;
        cpu_req0 = 1'b1;
        cpu_req3 = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick;
            if (ack0_cyc == 0 && mem_en0) en0_cnt++;
            if (ack3_cyc == 0 && mem_en3) en3_cnt++;
            if (cpu_ack0 && ack0_cyc == 0) begin ack0_cyc = n; cpu_req0 = 1'b0; end
            if (cpu_ack3 && ack3_cyc == 0) begin ack3_cyc = n; cpu_req3 = 1'b0; end
            vectors++; if (dbg_ack0 || dbg_ack3 || mem_we0 || mem_we3) begin $display("FAIL ws_stray: got dbg_ack/mem_we high cycle %0d want 0", n); miscompares++; end
        end
        vectors++; if (ack0_cyc != 2) begin $display("FAIL ws0_latency: got cycle %0d want 2", ack0_cyc); miscompares++; end
        vectors++; if (ack3_cyc != 5) begin $display("FAIL ws3_latency: got cycle %0d want 5", ack3_cyc); miscompares++; end
        vectors++; if (en0_cnt != 1) begin $display("FAIL ws0_en_len: got %0d want 1", en0_cnt); miscompares++; end
        vectors++; if (en3_cnt != 4) begin $display("FAIL ws3_en_len: got %0d want 4", en3_cnt); miscompares++; end
        vectors++; if (cpu_rd0 !== 8'h5A || cpu_rd3 !== 8'h5A) begin $display("FAIL ws_rd: got %h %h want 5a 5a", cpu_rd0, cpu_rd3); miscompares++; end
        vectors++; if (busy0 || busy3 || gnt_dbg0 || gnt_dbg3 || dbg_rd0 !== 8'h00 || dbg_rd3 !== 8'h00) begin $display("FAIL ws_end_state: got busy %b%b gnt %b%b want 00 00", busy0, busy3, gnt_dbg0, gnt_dbg3); miscompares++; end
        vectors++; if (mem_wd0 !== 8'h00 || mem_wd3 !== 8'h00) begin $display("FAIL ws_wd: got %h %h want 00 00", mem_wd0, mem_wd3); miscompares++; end
    endtask

    task automatic test_reset_mid_access;
        cpu_req = 1'b1;
        cpu_we  = 1'b0;
        cpu_adr = 8'h50;
        tick;
        vectors++; if (mem_en !== 1'b1) begin $display("FAIL mid_in_acc: got en=%b want 1", mem_en); miscompares++; end
        #2;
        reset = 1'b0;
        #1;
        vectors++; if (mem_en !== 1'b0 || busy !== 1'b0) begin $display("FAIL mid_async_drop: got en=%b busy=%b want 0 0", mem_en, busy); miscompares++; end
        vectors++; if (cpu_rd !== 8'h00) begin $display("FAIL mid_cpu_rd: got %h want 00", cpu_rd); miscompares++; end
        tick;
        vectors++; if (cpu_ack !== 1'b0 || mem_en !== 1'b0) begin $display("FAIL mid_no_ack: got ack=%b en=%b want 0 0", cpu_ack, mem_en); miscompares++; end
        reset = 1'b1;
        tick;
        vectors++; if (mem_en !== 1'b1 || mem_adr !== 8'h50) begin $display("FAIL mid_restart: got en=%b adr=%h want 1 50", mem_en, mem_adr); miscompares++; end
        tick;
        tick;
        vectors++; if (cpu_ack !== 1'b1 || cpu_rd !== 8'h77) begin $display("FAIL mid_complete: got ack=%b rd=%h want 1 77", cpu_ack, cpu_rd); miscompares++; end
        cpu_req = 1'b0;
        tick;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset    = 1'b0;
        cpu_req  = 1'b0;
        cpu_we   = 1'b0;
        cpu_adr  = 8'h00;
        cpu_wd   = 8'h00;
        dbg_req  = 1'b0;
        dbg_we   = 1'b0;
        dbg_adr  = 8'h00;
        dbg_wd   = 8'h00;
        cpu_req0 = 1'b0;
        cpu_req3 = 1'b0;
        no_req   = 1'b0;
        test_reset;
        test_cpu_read;
        test_dbg_write;
        test_back_to_back;
        test_wait_states;
        test_reset_mid_access;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-wide unified memory between two requesters:
  - the multicycle processor's memory interface (instruction fetch and lb/sb, driven by the controller states);
  - a debug/loader port used to preload programs and inspect memory.
- Performs round-robin arbitration and inserts programmable memory wait states.
- Returns a one-cycle ack per completed access; the processor controller holds its current state until ack.

Parameters:
- WIDTH, 8, data bus width.
- AWIDTH, 8, address bus width.
- WAIT_CYC, 1, extra memory cycles before read data is valid; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (low = reset).
- cpu_req  in  1  processor access request; held until cpu_ack.
- cpu_we  in  1  1 = write (sb), 0 = read (fetch/lb).
- cpu_adr  in  AWIDTH  processor address.
- cpu_wd  in  WIDTH  processor write data.
- cpu_rd  out  WIDTH  processor read data, registered.
- cpu_ack  out  1  one-cycle completion pulse to processor.
- dbg_req  in  1  debug access request; held until dbg_ack.
- dbg_we  in  1  debug write enable.
- dbg_adr  in  AWIDTH  debug address.
- dbg_wd  in  WIDTH  debug write data.
- dbg_rd  out  WIDTH  debug read data, registered.
- dbg_ack  out  1  one-cycle completion pulse to debug port.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; only valid while mem_en = 1.
- mem_adr  out  AWIDTH  memory address.
- mem_wd  out  WIDTH  memory write data.
- mem_rd  in  WIDTH  memory read data.
- busy  out  1  arbiter not in IDLE.
- gnt_dbg  out  1  current or last grant went to the debug port.

Behaviour:
- Reset (reset low, takes effect immediately, no clock needed):
  - state = IDLE.
  - mem_en, mem_we, cpu_ack, dbg_ack, busy = 0.
  - mem_adr, mem_wd, cpu_rd, dbg_rd = 0.
  - Wait counter = 0.
  - last_grant = DBG, so the CPU wins the first tie.
- Reset asserted mid-access:
  - The access is abandoned with no ack.
  - mem_en drops asynchronously.
  - Neither rd register is updated.
- IDLE state:
  - If no request is present, stay in IDLE.
  - If only one request is present, grant it.
  - If both requests are present, grant the requester not equal to last_grant.
  - On the granting edge:
    - latch the winner's we/adr/wd into the mem_* registers;
    - set the counter to WAIT_CYC;
    - update last_grant and gnt_dbg;
    - go to ACC.
- ACC state:
  - Outputs: mem_en = 1, mem_we = latched we; busy = 1.
  - If the counter is nonzero, decrement it each edge.
  - When the counter is 0 at an edge:
    - on a read, capture mem_rd into the winner's rd register (the other rd register is unchanged);
    - go to DONE.
  - ACC therefore lasts WAIT_CYC+1 cycles.
- DONE state:
  - mem_en = 0.
  - The winner's ack = 1 for exactly one cycle; busy = 1.
  - Next state is IDLE.
- Latency, measured from the first IDLE cycle with req high: ack is high in cycle WAIT_CYC+2. With the default WAIT_CYC = 1, ack is high in cycle 3.
- Handshake rules:
  - The requester holds req, we, adr and wd stable until it samples ack, then drops req at that edge.
  - If req is still high in the IDLE cycle after ack, it is treated as a new request.
  - Requester inputs are sampled only on the IDLE grant edge. A request withdrawn or changed during ACC/DONE does not affect the in-flight access, which still completes and acks.
- Arbitration guarantees:
  - cpu_ack and dbg_ack are never high simultaneously.
  - mem_en is never high outside ACC.
  - Under continuous requests from both ports, grants alternate strictly CPU, DBG, CPU, …
- Width rules:
  - The counter is 4 bits.
  - rd registers are WIDTH bits and hold their value until the next read completion for that port.
  - Writes never modify rd registers.
- The state encoding is 2 bits. The unused code returns to IDLE on the next edge with all outputs deasserted.

Test Plan:
- Reset with cpu_req = 1 held: while reset is low, mem_en = 0, acks = 0, cpu_rd = 0. Release reset → grant on the 1st edge, cpu_ack high in cycle 3 (WAIT_CYC = 1).
- CPU read adr = 0x10, memory returns 0x8C → mem_en high for 2 cycles with mem_adr = 0x10, mem_we = 0; cpu_rd = 0x8C when cpu_ack pulses; dbg_rd unchanged.
- DBG write adr = 0x44, wd = 0xA5 → mem_en = mem_we = 1 with mem_adr = 0x44, mem_wd = 0xA5; dbg_ack pulses once; cpu_rd and dbg_rd unchanged.
- Both ports request continuously for 6 accesses → grant order CPU, DBG, CPU, DBG, CPU, DBG; acks never overlap; gnt_dbg toggles each access.
- WAIT_CYC = 0 and WAIT_CYC = 3 builds → single read acks in cycle 2 and cycle 5 respectively; mem_en high for 1 and 4 cycles respectively.
- Reset pulsed low during ACC of a CPU read → mem_en drops immediately; no cpu_ack; cpu_rd stays 0; after release, a held cpu_req restarts the access from IDLE.
